// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a valid/ready holding register and pulsed error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
`timescale 1ns/1ps
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 core_clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic                 rxd_m, rxd_s;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 done, done_n;
  logic                 ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 perr_n;
`endif

  always_ff @(posedge core_clk) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge core_clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      done      <= done_n;
      frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    done_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Start bit is re-checked at mid-bit so short low glitches are ignored.
        if (cnt == CNT_MID) begin
          cnt_n = '0;
          if (!rxd_s) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_n = {rxd_s, shreg[DATA_BITS-1:1]};
          cnt_n   = '0;
          idx_n   = idx + 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          par_bad_n = ^{shreg, rxd_s};
          cnt_n     = '0;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
`endif
          if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
            done_n = !par_bad;
`else
            done_n = 1'b1;
`endif
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // shreg is untouched for at least a start-bit time after STOP, so it can feed the load directly.
  always_ff @(posedge core_clk) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus random traffic
// compared against a frame-level model (byte delivered iff stop good and parity good).
`timescale 1ns/1ps
module tb_uart_rx_byte;
  localparam int CPB = 4;

  logic       core_clk = 1'b0;
  logic       reset    = 1'b1;
  logic       rxd      = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #10 core_clk = ~core_clk;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .core_clk  (core_clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: records accepted bytes and counts pulse cycles.
  logic [7:0] obs_mem [0:255];
  int obs_wr = 0, vcyc = 0, ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;
  always @(negedge core_clk) begin
    if (!reset) begin
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) begin
        obs_mem[obs_wr] = rx_data;
        obs_wr++;
      end
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
    end
  end

  logic [7:0] exp_mem [0:255];
  int exp_wr = 0;
  int obs_base, exp_base, vcyc_base, ferr_base, ovr_base, perr_base;

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) tick();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic frame(input logic [7:0] d, input logic stop_b, input logic pf = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((^d) ^ pf);
    send_bit(stop_b);
  endtask
`else
  task automatic frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask
`endif

  task automatic push_exp(input logic [7:0] d);
    exp_mem[exp_wr] = d;
    exp_wr++;
  endtask

  task automatic begin_phase();
    obs_base  = obs_wr;
    exp_base  = exp_wr;
    vcyc_base = vcyc;
    ferr_base = ferr_cnt;
    ovr_base  = ovr_cnt;
    perr_base = perr_cnt;
  endtask

  task automatic phase_check(input logic ready_held, input int e_ferr, input int e_ovr, input int e_perr);
    int n_obs, n_exp, n_min;
    repeat (3 * CPB) tick();
    n_obs = obs_wr - obs_base;
    n_exp = exp_wr - exp_base;
    n_min = (n_obs < n_exp) ? n_obs : n_exp;
    check("byte_count", n_obs, n_exp);
    for (int i = 0; i < n_min; i++)
      check("byte", obs_mem[obs_base + i], exp_mem[exp_base + i]);
    if (ready_held) check("valid_cycles", vcyc - vcyc_base, n_exp);
    check("frame_err_count", ferr_cnt - ferr_base, e_ferr);
    check("overrun_count", ovr_cnt - ovr_base, e_ovr);
`ifdef UART_RX_PARITY_EN
    check("parity_err_count", perr_cnt - perr_base, e_perr);
`else
    check("parity_none", e_perr, 0);
`endif
    begin_phase();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       s, pf;
    int         g, e_ferr, e_perr;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("rst_parity_err", parity_err, 1'b0);
`endif
    reset = 1'b0;
    repeat (2) tick();
    begin_phase();

    // Basic frame with latency and single-cycle valid
    frame(8'h0F, 1'b1);
    tick();
    check("lat_pre", rx_valid, 1'b0);
    tick();
    check("lat_valid", rx_valid, 1'b1);
    check("lat_data", rx_data, 8'h0F);
    push_exp(8'h0F);
    tick();
    check("valid_one_cycle", rx_valid, 1'b0);
    phase_check(1'b1, 0, 0, 0);

    // Start-bit glitch is ignored
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (3 * CPB) tick();
    check("glitch_no_valid", rx_valid, 1'b0);
    frame(8'hA5, 1'b1);
    push_exp(8'hA5);
    phase_check(1'b1, 0, 0, 0);

    // Bad stop bit followed by a held break
    frame(8'h55, 1'b0);
    tick();
    check("ferr_pulse", frame_err, 1'b1);
    tick();
    check("ferr_single", frame_err, 1'b0);
    repeat (18) tick();
    rxd = 1'b1;
    repeat (2 * CPB) tick();
    frame(8'h3C, 1'b1);
    push_exp(8'h3C);
    phase_check(1'b1, 1, 0, 0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    frame(8'h12, 1'b1);
    send_bit(1'b1);
    frame(8'h34, 1'b1);
    repeat (3) tick();
    check("hold_valid", rx_valid, 1'b1);
    check("hold_data", rx_data, 8'h12);
    rx_ready = 1'b1;
    push_exp(8'h12);
    tick();
    rx_ready = 1'b0;
    check("consume_clears", rx_valid, 1'b0);
    check("consume_keeps_data", rx_data, 8'h12);
    phase_check(1'b0, 0, 1, 0);
    rx_ready = 1'b1;

    // Back-to-back frames, no idle gap
    frame(8'h00, 1'b1);
    frame(8'hFF, 1'b1);
    push_exp(8'h00);
    push_exp(8'hFF);
    phase_check(1'b1, 0, 0, 0);

    // Reset during data bit 3
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rxd = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    rxd   = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_valid", rx_valid, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    repeat (3 * CPB) tick();
    frame(8'h81, 1'b1);
    push_exp(8'h81);
    phase_check(1'b1, 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0);
    push_exp(8'h07);
    send_bit(1'b1);
    frame(8'h07, 1'b1, 1'b1);
    phase_check(1'b1, 0, 0, 1);
    frame(8'h07, 1'b0, 1'b1);
    tick();
    check("both_ferr", frame_err, 1'b1);
    check("both_perr", parity_err, 1'b1);
    rxd = 1'b1;
    phase_check(1'b1, 1, 0, 1);
`endif

    // Random traffic against the frame-level model
    e_ferr = 0;
    e_perr = 0;
    for (int k = 0; k < 40; k++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 6) != 0);
`ifdef UART_RX_PARITY_EN
      pf = ($urandom_range(0, 7) == 0);
      frame(d, s, pf);
`else
      pf = 1'b0;
      frame(d, s);
`endif
      if (!s) e_ferr++;
      if (pf) e_perr++;
      if (s && !pf) push_exp(d);
      g = s ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      if (s && g >= 2 && $urandom_range(0, 1) == 1) begin
        rxd = 1'b0;
        tick();
      end
      repeat (g) send_bit(1'b1);
    end
    rxd = 1'b1;
    phase_check(1'b1, e_ferr, 0, e_perr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
